wb_stage: RTL and testbench

//  MEM/WB pipeline register plus write-back arbiter; sole driver of the regfile write port (we/waddr/wdata).

---
 rtl/wb_stage.sv | 233 +++++++++++++++++++++++
 tb/tb_wb_stage.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage
// MEM/WB pipeline register plus write-back arbiter. This block is the only
// driver of the register-file write port. In-order results from the MEM stage
// are merged with out-of-order load returns, which are queued in a small FIFO.
// A per-register busy scoreboard tracks loads that have not yet written back;
// ID uses it to detect load-use hazards.
//
// Ports
//   clk_i            rising-edge clock
//   rst_ni           asynchronous reset, active-low
//   stall_i          hold the MEM/WB stage register
//   flush_i          kill the instruction entering the stage register
//   mem_we_i         MEM-stage result writes a register
//   mem_waddr_i      MEM-stage destination register
//   mem_wdata_i      MEM-stage result data
//   ld_issue_i       load issued to data memory this cycle
//   ld_issue_addr_i  destination register of the issued load
//   ld_rvalid_i      load return data valid
//   ld_raddr_i       destination register of the returning load
//   ld_rdata_i       returning load data
//   ld_rready_o      queue can accept a return (count < FIFO_DEPTH)
//   wb_we_o          regfile write enable
//   wb_waddr_o       regfile write address
//   wb_wdata_o       regfile write data
//   busy_mask_o      bit r = load to register r outstanding
//   fifo_count_o     entries currently queued
// ---------------------------------------------------------------------------
module wb_stage #(
  parameter  int DATA_W     = 32,
  parameter  int ADDR_W     = 5,
  parameter  int FIFO_DEPTH = 4,
  localparam int NREG       = 2**ADDR_W,
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_waddr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic              ld_issue_i,
  input  logic [ADDR_W-1:0] ld_issue_addr_i,
  input  logic              ld_rvalid_i,
  input  logic [ADDR_W-1:0] ld_raddr_i,
  input  logic [DATA_W-1:0] ld_rdata_i,
  output logic              ld_rready_o,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_waddr_o,
  output logic [DATA_W-1:0] wb_wdata_o,
  output logic [NREG-1:0]   busy_mask_o,
  output logic [CNT_W-1:0]  fifo_count_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // One-hot decode of a register index into a scoreboard mask.
  function automatic logic [NREG-1:0] reg_onehot(input logic [ADDR_W-1:0] idx);
    logic [NREG-1:0] m;
    m = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

  // Stage register
  logic              s_we_q,   s_we_d;
  logic [ADDR_W-1:0] s_addr_q, s_addr_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic              s_done_q, s_done_d;

  // Load-return queue
  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;

  // Scoreboard and last driven write-port values
  logic [NREG-1:0]   busy_q,      busy_d;
  logic [ADDR_W-1:0] last_addr_q;
  logic [DATA_W-1:0] last_data_q;

  // Arbiter / handshake decisions
  logic              s_grant_s;
  logic              pop_s;
  logic              push_s;
  logic              rready_s;
  logic [ADDR_W-1:0] head_addr_s;
  logic [DATA_W-1:0] head_data_s;
  logic              wb_we_s;
  logic [ADDR_W-1:0] wb_waddr_s;
  logic [DATA_W-1:0] wb_wdata_s;

  // Grant, pop and push decisions; ready is taken from the pre-pop count,
  // so a full queue refuses a return even in a cycle where it pops.
  always_comb begin
    head_addr_s = fifo_addr_q[rd_ptr_q];
    head_data_s = fifo_data_q[rd_ptr_q];
    s_grant_s   = s_we_q && (s_addr_q != '0) && !s_done_q;
    pop_s       = !s_grant_s && (count_q != '0);
    rready_s    = (count_q < CNT_W'(FIFO_DEPTH));
    push_s      = ld_rvalid_i && rready_s && (ld_raddr_i != '0);
  end

  // Write-port mux: stage register first, then queue head; address/data
  // hold their last driven values when nothing writes.
  always_comb begin
    wb_we_s    = 1'b0;
    wb_waddr_s = last_addr_q;
    wb_wdata_s = last_data_q;
    if (s_grant_s) begin
      wb_we_s    = 1'b1;
      wb_waddr_s = s_addr_q;
      wb_wdata_s = s_data_q;
    end else if (pop_s) begin
      wb_we_s    = 1'b1;
      wb_waddr_s = head_addr_s;
      wb_wdata_s = head_data_s;
    end else begin
      wb_we_s    = 1'b0;
    end
  end

  // Stage register next state; while stalled, s_done remembers that the
  // held instruction has already used the write port.
  always_comb begin
    s_we_d   = s_we_q;
    s_addr_d = s_addr_q;
    s_data_d = s_data_q;
    s_done_d = s_done_q;
    if (!stall_i) begin
      if (flush_i) begin
        s_we_d   = 1'b0;
        s_done_d = 1'b0;
      end else begin
        s_we_d   = mem_we_i;
        s_addr_d = mem_waddr_i;
        s_data_d = mem_wdata_i;
        s_done_d = 1'b0;
      end
    end else begin
      s_done_d = s_done_q | s_grant_s;
    end
  end

  // Queue pointer/count next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Scoreboard next state; the set is applied after the clear so set wins.
  always_comb begin
    busy_d = busy_q;
    if (pop_s) begin
      busy_d = busy_d & ~reg_onehot(head_addr_s);
    end else begin
      busy_d = busy_d;
    end
    if (ld_issue_i && (ld_issue_addr_i != '0)) begin
      busy_d = busy_d | reg_onehot(ld_issue_addr_i);
    end else begin
      busy_d = busy_d;
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_we_q      <= 1'b0;
      s_addr_q    <= '0;
      s_data_q    <= '0;
      s_done_q    <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      busy_q      <= '0;
      last_addr_q <= '0;
      last_data_q <= '0;
    end else begin
      s_we_q      <= s_we_d;
      s_addr_q    <= s_addr_d;
      s_data_q    <= s_data_d;
      s_done_q    <= s_done_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      last_addr_q <= wb_waddr_s;
      last_data_q <= wb_wdata_s;
    end
  end

  // Queue storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
    end else if (push_s) begin
      fifo_addr_q[wr_ptr_q] <= ld_raddr_i;
      fifo_data_q[wr_ptr_q] <= ld_rdata_i;
    end else begin
      fifo_addr_q[wr_ptr_q] <= fifo_addr_q[wr_ptr_q];
      fifo_data_q[wr_ptr_q] <= fifo_data_q[wr_ptr_q];
    end
  end

  assign ld_rready_o  = rready_s;
  assign wb_we_o      = wb_we_s;
  assign wb_waddr_o   = wb_waddr_s;
  assign wb_wdata_o   = wb_wdata_s;
  assign busy_mask_o  = busy_q;
  assign fifo_count_o = count_q;

endmodule

// File: tb/tb_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_wb_stage
// Self-checking bench for wb_stage: directed scenarios with literal
// expectations, then a randomized phase. A transaction-level model (a queue of
// pending returns, a busy bitmap and the stage contents) predicts every output
// each cycle; it is compared at the falling edge.
// ---------------------------------------------------------------------------
module tb_wb_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int D  = 4;
  localparam int NR = 32;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall, flush, mem_we, ld_issue, ld_rvalid;
  logic [AW-1:0] mem_waddr, ld_issue_addr, ld_raddr;
  logic [DW-1:0] mem_wdata, ld_rdata;
  logic          ld_rready, wb_we;
  logic [AW-1:0] wb_waddr;
  logic [DW-1:0] wb_wdata;
  logic [NR-1:0] busy_mask;
  logic [CW-1:0] fifo_count;

  always #5 clk = ~clk;

  wb_stage #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(D)) dut (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .flush_i(flush),
    .mem_we_i(mem_we), .mem_waddr_i(mem_waddr), .mem_wdata_i(mem_wdata),
    .ld_issue_i(ld_issue), .ld_issue_addr_i(ld_issue_addr),
    .ld_rvalid_i(ld_rvalid), .ld_raddr_i(ld_raddr), .ld_rdata_i(ld_rdata),
    .ld_rready_o(ld_rready), .wb_we_o(wb_we), .wb_waddr_o(wb_waddr),
    .wb_wdata_o(wb_wdata), .busy_mask_o(busy_mask), .fifo_count_o(fifo_count)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  // reference model state
  ent_t          mq[$];
  logic          m_s_we;
  logic [AW-1:0] m_s_addr;
  logic [DW-1:0] m_s_data;
  bit            m_s_written;
  logic [NR-1:0] m_busy;
  logic [AW-1:0] m_last_a;
  logic [DW-1:0] m_last_d;
  int            outst[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    outst.delete();
    m_s_we = 1'b0; m_s_addr = '0; m_s_data = '0; m_s_written = 1'b0;
    m_busy = '0; m_last_a = '0; m_last_d = '0;
  endtask

  function automatic bit s_wants();
    return m_s_we && (m_s_addr != 0) && !m_s_written;
  endfunction

  // per-cycle comparison of every output against the model
  task automatic check_outputs();
    logic          e_we;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_d;
    e_we = 1'b0; e_a = m_last_a; e_d = m_last_d;
    if (s_wants()) begin
      e_we = 1'b1; e_a = m_s_addr; e_d = m_s_data;
    end else if (mq.size() > 0) begin
      e_we = 1'b1; e_a = mq[0].a; e_d = mq[0].d;
    end
    chk("m_wb_we",     64'(wb_we),      64'(e_we));
    chk("m_wb_waddr",  64'(wb_waddr),   64'(e_a));
    chk("m_wb_wdata",  64'(wb_wdata),   64'(e_d));
    chk("m_ld_rready", 64'(ld_rready),  64'(mq.size() < D));
    chk("m_count",     64'(fifo_count), 64'(mq.size()));
    chk("m_busy",      64'(busy_mask),  64'(m_busy));
  endtask

  // advance the model by one clock edge using the current inputs
  task automatic model_step();
    bit can_push;
    can_push = (mq.size() < D);
    if (s_wants()) begin
      m_last_a = m_s_addr; m_last_d = m_s_data;
      if (stall) m_s_written = 1'b1;
    end else if (mq.size() > 0) begin
      m_last_a = mq[0].a; m_last_d = mq[0].d;
      m_busy[mq[0].a] = 1'b0;
      mq.delete(0);
    end
    if (ld_rvalid && can_push && ld_raddr != 0) mq.push_back('{ld_raddr, ld_rdata});
    if (ld_issue && ld_issue_addr != 0) m_busy[ld_issue_addr] = 1'b1;
    if (!stall) begin
      if (flush) begin
        m_s_we = 1'b0; m_s_written = 1'b0;
      end else begin
        m_s_we = mem_we; m_s_addr = mem_waddr; m_s_data = mem_wdata; m_s_written = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 1'b0; flush = 1'b0; mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
    ld_issue = 1'b0; ld_issue_addr = '0; ld_rvalid = 1'b0; ld_raddr = '0; ld_rdata = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    int ord[4];
    int idx;
    int r;
    bit accepted;
    ord = '{13, 11, 10, 12};

    // reset state
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #2;
    chk("rst_wb_we",  64'(wb_we),      64'h0);
    chk("rst_waddr",  64'(wb_waddr),   64'h0);
    chk("rst_wdata",  64'(wb_wdata),   64'h0);
    chk("rst_rready", 64'(ld_rready),  64'h1);
    chk("rst_count",  64'(fifo_count), 64'h0);
    chk("rst_busy",   64'(busy_mask),  64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: single pipeline write, one-cycle latency, then hold when idle
    mem_we = 1'b1; mem_waddr = 5'd5; mem_wdata = 32'hDEADBEEF;
    tick();
    chk("t1_we",    64'(wb_we),    64'h1);
    chk("t1_waddr", 64'(wb_waddr), 64'h5);
    chk("t1_wdata", 64'(wb_wdata), 64'hDEADBEEF);
    mem_we = 1'b0;
    tick();
    chk("t1_idle_we",    64'(wb_we),    64'h0);
    chk("t1_hold_waddr", 64'(wb_waddr), 64'h5);
    chk("t1_hold_wdata", 64'(wb_wdata), 64'hDEADBEEF);

    // 2: load to r7, busy until its write-back
    ld_issue = 1'b1; ld_issue_addr = 5'd7;
    tick();
    ld_issue = 1'b0;
    chk("t2_busy_set", 64'(busy_mask), 64'h80);
    ld_rvalid = 1'b1; ld_raddr = 5'd7; ld_rdata = 32'h1234;
    tick();
    ld_rvalid = 1'b0;
    chk("t2_we",        64'(wb_we),     64'h1);
    chk("t2_waddr",     64'(wb_waddr),  64'h7);
    chk("t2_wdata",     64'(wb_wdata),  64'h1234);
    chk("t2_busy_held", 64'(busy_mask), 64'h80);
    tick();
    chk("t2_busy_clr", 64'(busy_mask),  64'h0);
    chk("t2_count",    64'(fifo_count), 64'h0);

    // 3: S busy every cycle fills the queue; stall drains it in order
    for (int i = 0; i < 4; i++) begin
      mem_we = 1'b1; mem_waddr = 5'd3; mem_wdata = 32'h300 + 32'(i);
      ld_issue = 1'b1; ld_issue_addr = AW'(10 + i);
      tick();
    end
    ld_issue = 1'b0;
    chk("t3_busy4", 64'(busy_mask), 64'h3C00);
    for (int j = 0; j < 4; j++) begin
      mem_wdata = 32'h310 + 32'(j);
      ld_rvalid = 1'b1; ld_raddr = AW'(ord[j]); ld_rdata = 32'hA000 + 32'(ord[j]);
      tick();
      chk("t3_fill_count", 64'(fifo_count), 64'(j + 1));
      chk("t3_s_wins",     64'(wb_waddr),   64'h3);
    end
    chk("t3_full_rready", 64'(ld_rready), 64'h0);
    mem_wdata = 32'h314; ld_raddr = 5'd9; ld_rdata = 32'hBAD;
    tick();
    ld_rvalid = 1'b0;
    chk("t3_refused", 64'(fifo_count), 64'h4);
    chk("t3_s_wdata", 64'(wb_wdata),   64'h314);
    stall = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("t3_drain_waddr", 64'(wb_waddr), 64'(ord[k]));
      chk("t3_drain_wdata", 64'(wb_wdata), 64'h0000A000 + 64'(ord[k]));
      tick();
    end
    chk("t3_drained_we",   64'(wb_we),     64'h0);
    chk("t3_drained_busy", 64'(busy_mask), 64'h0);
    stall = 1'b0; mem_we = 1'b0;

    // 4: r0 targets are ignored
    mem_we = 1'b1; mem_waddr = 5'd0; mem_wdata = 32'h44;
    ld_rvalid = 1'b1; ld_raddr = 5'd0; ld_rdata = 32'h77;
    tick();
    ld_rvalid = 1'b0; mem_we = 1'b0;
    chk("t4_we",    64'(wb_we),      64'h0);
    chk("t4_count", 64'(fifo_count), 64'h0);
    chk("t4_busy",  64'(busy_mask),  64'h0);

    // 5: flush kills the stage write but not queued loads
    flush = 1'b1; mem_we = 1'b1; mem_waddr = 5'd6; mem_wdata = 32'h66;
    tick();
    chk("t5_flush_we", 64'(wb_we), 64'h0);
    flush = 1'b0; mem_we = 1'b0; ld_issue = 1'b1; ld_issue_addr = 5'd20;
    tick();
    ld_issue = 1'b0;
    flush = 1'b1; mem_we = 1'b1; ld_rvalid = 1'b1; ld_raddr = 5'd20; ld_rdata = 32'h55;
    tick();
    flush = 1'b0; mem_we = 1'b0; ld_rvalid = 1'b0;
    chk("t5_ld_we",    64'(wb_we),    64'h1);
    chk("t5_ld_waddr", 64'(wb_waddr), 64'h14);
    chk("t5_ld_wdata", 64'(wb_wdata), 64'h55);
    tick();
    chk("t5_busy", 64'(busy_mask), 64'h0);

    // 6: asynchronous reset in the middle of a drain
    for (int i = 0; i < 3; i++) begin
      mem_we = 1'b1; mem_waddr = 5'd4; mem_wdata = 32'h400 + 32'(i);
      ld_issue = 1'b1; ld_issue_addr = AW'(21 + i);
      tick();
    end
    ld_issue = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ld_rvalid = 1'b1; ld_raddr = AW'(21 + i); ld_rdata = 32'hB00 + 32'(i);
      tick();
    end
    ld_rvalid = 1'b0;
    chk("t6_count3", 64'(fifo_count), 64'h3);
    stall = 1'b1;
    tick();
    chk("t6_draining", 64'(wb_waddr), 64'h15);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_we",     64'(wb_we),      64'h0);
    chk("t6_rst_count",  64'(fifo_count), 64'h0);
    chk("t6_rst_busy",   64'(busy_mask),  64'h0);
    chk("t6_rst_rready", 64'(ld_rready),  64'h1);
    chk("t6_rst_waddr",  64'(wb_waddr),   64'h0);
    model_reset();
    idle_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // randomized traffic obeying the ID protocol
    for (int c = 0; c < 3000; c++) begin
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      mem_we = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 31);
      if (m_busy[r]) r = 0;
      mem_waddr = AW'(r);
      mem_wdata = $urandom;
      ld_issue = ($urandom_range(0, 2) == 0);
      r = $urandom_range(1, 31);
      if (m_busy[r] || r == int'(mem_waddr)) ld_issue = 1'b0;
      ld_issue_addr = AW'(r);
      idx = -1;
      ld_rdata = $urandom;
      if (outst.size() > 0 && $urandom_range(0, 1) == 1) begin
        idx = $urandom_range(0, outst.size() - 1);
        ld_rvalid = 1'b1; ld_raddr = AW'(outst[idx]);
      end else if ($urandom_range(0, 15) == 0) begin
        ld_rvalid = 1'b1; ld_raddr = '0;
      end else begin
        ld_rvalid = 1'b0; ld_raddr = AW'($urandom_range(0, 31));
      end
      accepted = ld_rvalid && (mq.size() < D) && (idx >= 0);
      tick();
      if (accepted) outst.delete(idx);
      if (ld_issue) outst.push_back(int'(ld_issue_addr));
    end
    idle_inputs();
    for (int c = 0; c < 8; c++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
